count_seq_monitor: RTL
======================

# count_seq_monitor

Downstream integrity monitor for the synchronous up-counter. Samples the counter's `count` output each qualified clock and locks onto the increment sequence. While locked it reports every wrap-around (15 → 0) and flags every out-of-sequence value. It also keeps saturating error and free-running wrap tallies for status readout.

## Interface
Parameters:
- `WIDTH`, default 4, width of the monitored count.
- `LOCK_CNT`, default 3, consecutive correct increments required to declare lock (≥1).
- `WRAP_W`, default 8, width of the wrap tally.
- `ERR_W`, default 8, width of the error tally.

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `rst`, in, 1, reset; asynchronous, active-high.
- `count_in`, in, WIDTH, counter value under observation.
- `count_valid`, in, 1, qualifies `count_in` this cycle. The integrator drives it low while the counter is held in reset.
- `clr_err`, in, 1, synchronous clear of `err_sticky` and `err_count`.
- `locked`, out, 1, high while in LOCKED.
- `wrap_pulse`, out, 1, one-cycle pulse per detected wrap.
- `wrap_count`, out, WRAP_W, free-running wrap tally; rolls over modulo 2^WRAP_W.
- `err_pulse`, out, 1, one-cycle pulse per sequence error.
- `err_sticky`, out, 1, set on any error; held until `clr_err` or reset.
- `err_count`, out, ERR_W, error tally; saturates at 2^ERR_W−1.

## Operation
- Internal state: `prev` (WIDTH bits), `good` (counts 0..LOCK_CNT), and a 3-state FSM.
- FSM states: UNLOCKED, ACQUIRE, LOCKED.
- Expected value: `exp = prev + 1` modulo 2^WIDTH. A match is `count_in == exp`. Equal values (a held count) and skipped values are mismatches.
- UNLOCKED: on `count_valid`, load `prev ← count_in`, clear `good`, go to ACQUIRE.
- ACQUIRE: on `count_valid`, load `prev ← count_in`.
  - Match: `good` increments. When the new value of `good` equals LOCK_CNT, go to LOCKED.
  - Mismatch: `good ← 0` and stay in ACQUIRE. No error is reported, because the block is not locked.
- LOCKED: on `count_valid`, load `prev ← count_in`.
  - Match: stay in LOCKED. If `prev == 2^WIDTH−1` and `count_in == 0`, assert `wrap_pulse` and increment `wrap_count`.
  - Mismatch: assert `err_pulse`, set `err_sticky`, increment `err_count` unless it is saturated, clear `good`, go to ACQUIRE.
- When `count_valid` is low, nothing changes in any state: `prev`, `good` and the state all hold. Pulses are low.
- No wrap is reported outside LOCKED. This includes the transition cycle into LOCKED.
- `clr_err` together with an error in the same cycle: the error wins. `err_sticky` ends at 1 and `err_count` ends at 1.
- `clr_err` has no effect on the FSM, `prev`, `good`, `locked` or the wrap tally.

## Timing
- All outputs are registered. A sample taken at rising edge N produces its response after edge N, visible during cycle N+1.
- `wrap_pulse` and `err_pulse` are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- `locked` rises after the edge that accepts the LOCK_CNT-th consecutive match. With default parameters and a clean stream starting at edge 0, `locked` is high after edge 3.
- `locked` falls after the edge that samples a mismatch, in the same cycle that `err_pulse` is high.
- Reset asserted at any time, including mid-acquire or mid-lock: all outputs go to 0 immediately (asynchronously). FSM → UNLOCKED, `prev` → 0, `good` → 0, both tallies → 0, `err_sticky` → 0.
- Reset deassertion is synchronous to `clk` at the integration level. The first possible state change is at the first edge after `rst` falls.

## Test plan
- Reset, then valid stream 0,1,2,3 on consecutive cycles:
  - `locked` = 0 after edges 0–2.
  - `locked` = 1 after edge 3.
  - No pulses.
  - All outputs 0 while `rst` = 1.
- Locked, stream continues 4..15,0,1:
  - Exactly one `wrap_pulse`, in the cycle after 0 is sampled.
  - `wrap_count` = 1.
  - `err_count` = 0.
- Locked at 7, inject 9:
  - `err_pulse` for one cycle.
  - `err_sticky` = 1, `err_count` = 1, `locked` = 0.
  - Then stream 10,11,12 → `locked` = 1 after the third match.
- Locked at 5, `count_valid` low for 4 cycles, then 6:
  - No error.
  - `locked` stays 1 throughout.
- Force `err_count` to 255 via repeated lock/mismatch cycles, then one more error:
  - `err_count` stays 255.
  - `err_pulse` still fires.
  - Assert `clr_err` in the same cycle as a new error → `err_count` = 1, `err_sticky` = 1.
- Assert `rst` asynchronously mid-LOCKED, between clock edges:
  - `locked`, `wrap_count`, `err_count` and `err_sticky` go to 0 before the next edge.
  - After release, stream 3,4,5,6 relocks with `locked` = 1 after the fourth sample.

Source files
------------

// File: rtl/count_seq_monitor_if.sv
// count_seq_monitor_if: bus between a counter observer and the sequence monitor
//   count_in/count_valid : sampled counter value and its qualifier
//   clr_err              : synchronous clear of the error status
//   locked, wrap_*, err_*: monitor status outputs
interface count_seq_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic [WIDTH-1:0]  count_in;
  logic              count_valid;
  logic              clr_err;
  logic              locked;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              err_pulse;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_count;
  modport master (
    output count_in, count_valid, clr_err,
    input  locked, wrap_pulse, wrap_count, err_pulse, err_sticky, err_count
  );
  modport slave (
    input  count_in, count_valid, clr_err,
    output locked, wrap_pulse, wrap_count, err_pulse, err_sticky, err_count
  );
endinterface

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: locks onto an incrementing counter, reports wraps and sequence errors
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of count_seq_monitor_if (count_in/count_valid/clr_err in, status out)
module count_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8
) (
  input logic                 clk,
  input logic                 rst,
  count_seq_monitor_if.slave  bus
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_prev, w_exp;
  logic [GW-1:0]     r_good, w_good_inc, w_good_next;
  logic              w_match, w_wrap, w_err;
  logic              r_locked, r_wrap_pulse, r_err_pulse, r_err_sticky;
  logic [WRAP_W-1:0] r_wrap_count;
  logic [ERR_W-1:0]  r_err_count;
  always_comb begin
    w_exp       = r_prev + 1'b1;
    w_match     = bus.count_in == w_exp;
    w_good_inc  = r_good + 1'b1;
    // a match from an all-ones prev is necessarily the 15->0 style wrap
    w_wrap      = bus.count_valid && r_state == LOCKED && w_match && &r_prev;
    w_err       = bus.count_valid && r_state == LOCKED && !w_match;
    w_next      = r_state;
    w_good_next = r_good;
    if (bus.count_valid) begin
      w_next = r_state == UNLOCKED ? ACQUIRE :
               r_state == ACQUIRE  ? (w_match && w_good_inc == GW'(LOCK_CNT) ? LOCKED : ACQUIRE) :
               (w_match ? LOCKED : ACQUIRE);
      w_good_next = r_state == ACQUIRE && w_match ? w_good_inc :
                    r_state == LOCKED && w_match  ? r_good : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= UNLOCKED;
      r_prev       <= '0;
      r_good       <= '0;
      r_locked     <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_wrap_count <= '0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_next;
      r_good       <= w_good_next;
      r_prev       <= bus.count_valid ? bus.count_in : r_prev;
      r_locked     <= w_next == LOCKED;
      r_wrap_pulse <= w_wrap;
      r_err_pulse  <= w_err;
      r_wrap_count <= r_wrap_count + WRAP_W'(w_wrap);
      // an error in the same cycle as clr_err restarts the tally at one
      if (w_err) begin
        r_err_sticky <= 1'b1;
        r_err_count  <= bus.clr_err ? ERR_W'(1) : (&r_err_count ? r_err_count : r_err_count + 1'b1);
      end else if (bus.clr_err) begin
        r_err_sticky <= 1'b0;
        r_err_count  <= '0;
      end
    end
  end
  assign bus.locked     = r_locked;
  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.wrap_count = r_wrap_count;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_count  = r_err_count;
endmodule
